// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants, mixer FSM states and clog2 for the audio test path
package audio_pkg;

  localparam int SAMPLE_DIV_48K = 1042;

  typedef enum logic [1:0] {IDLE, SNAP, ACCUM, SAT} mix_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/square_voice_mixer_if.sv
// rtl/square_voice_mixer_if.sv - mixed sample stream from the voice mixer to its consumer
interface square_voice_mixer_if #(parameter int OUT_W = 32);

  logic signed [OUT_W-1:0] sample_out;
  logic                    sample_valid;
  logic                    sample_ready;

  modport master (output sample_out, output sample_valid, input sample_ready);
  modport slave  (input sample_out, input sample_valid, output sample_ready);

endinterface

// File: rtl/square_voice.sv
// rtl/square_voice.sv - one programmable-period square voice; period is period-1 in clock cycles
module square_voice #(
  parameter int PERIOD_W = 19
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  output logic                phase,
  output logic                active
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] cur_period;
  logic [PERIOD_W:0]   half;

  // cur_period is captured only on reload, so a period edit never splits a running cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      cur_period <= '0;
    end else if (cnt == '0) begin
      cnt        <= period;
      cur_period <= period;
    end else begin
      cnt <= cnt - PERIOD_W'(1);
    end
  end

  // upper half of the count, inclusive, so an odd period-1 gives an exact 50% duty
  assign half   = ({1'b0, cur_period} + (PERIOD_W+1)'(1)) >> 1;
  assign phase  = ({1'b0, cnt} >= half);
  assign active = (cur_period != '0);

endmodule

// File: rtl/square_voice_mixer.sv
// rtl/square_voice_mixer.sv - mixes NUM_VOICES square voices into one saturated sample per tick
module square_voice_mixer
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W   = 19,
  parameter int AMP_W      = 24,
  parameter int OUT_W      = 32,
  parameter int SAMPLE_DIV = SAMPLE_DIV_48K
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_VOICES*PERIOD_W-1:0] period,
  input  logic [NUM_VOICES-1:0]          voice_en,
  input  logic [AMP_W-1:0]               amplitude,
  input  logic                           clear_overrun,
  square_voice_mixer_if.master           sample,
  output logic                           overrun
);

  localparam int ACC_W = AMP_W + clog2(NUM_VOICES) + 1;
  localparam int IDX_W = (NUM_VOICES > 1) ? clog2(NUM_VOICES) : 1;
  localparam int DIV_W = clog2(SAMPLE_DIV);

  logic [DIV_W-1:0]        tick_cnt;
  logic                    tick;
  logic [NUM_VOICES-1:0]   phase;
  logic [NUM_VOICES-1:0]   active;
  logic [NUM_VOICES-1:0]   snap_phase;
  logic [NUM_VOICES-1:0]   snap_en;
  logic [AMP_W-1:0]        snap_amp;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] amp_ext;
  logic signed [ACC_W-1:0] contrib;
  logic signed [OUT_W-1:0] sat;
  logic [IDX_W-1:0]        idx;
  mix_state_t              state, state_next;

  assign tick = (tick_cnt == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tick_cnt <= DIV_W'(SAMPLE_DIV - 1);
    else          tick_cnt <= tick ? DIV_W'(SAMPLE_DIV - 1) : tick_cnt - DIV_W'(1);
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    square_voice #(.PERIOD_W(PERIOD_W)) u_voice (
      .clock   (clock),
      .reset_n (reset_n),
      .period  (period[v*PERIOD_W +: PERIOD_W]),
      .phase   (phase[v]),
      .active  (active[v])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = SNAP;
      SNAP:    state_next = ACCUM;
      ACCUM:   if (idx == IDX_W'(NUM_VOICES - 1)) state_next = SAT;
      SAT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign amp_ext = $signed({{(ACC_W-AMP_W){1'b0}}, snap_amp});

  always_comb begin
    contrib = '0;
    if (snap_en[idx]) contrib = snap_phase[idx] ? amp_ext : -amp_ext;
  end

  if (ACC_W > OUT_W) begin : g_clamp
    localparam logic signed [ACC_W-1:0] HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    always_comb begin
      if (acc > HI)      sat = HI[OUT_W-1:0];
      else if (acc < LO) sat = LO[OUT_W-1:0];
      else               sat = acc[OUT_W-1:0];
    end
  end else begin : g_extend
    assign sat = OUT_W'(acc);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap_phase          <= '0;
      snap_en             <= '0;
      snap_amp            <= '0;
      acc                 <= '0;
      idx                 <= '0;
      sample.sample_out   <= '0;
      sample.sample_valid <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      case (state)
        SNAP: begin
          snap_phase <= phase;
          snap_en    <= voice_en & active;
          snap_amp   <= amplitude;
          acc        <= '0;
          idx        <= '0;
        end
        ACCUM: begin
          acc <= acc + contrib;
          idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
      // a fresh sample always replaces the pending one; only an unaccepted replacement is an overrun
      if (state == SAT) begin
        sample.sample_out   <= sat;
        sample.sample_valid <= 1'b1;
      end else if (sample.sample_valid && sample.sample_ready) begin
        sample.sample_valid <= 1'b0;
      end
      if (state == SAT && sample.sample_valid && !sample.sample_ready) overrun <= 1'b1;
      else if (clear_overrun)                                          overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_square_voice_mixer.sv
// tb/tb_square_voice_mixer.sv - checks two mixer configurations against a cycle-level stream model
module tb_square_voice_mixer;

  localparam int NV = 4;
  localparam int PW = 19;
  localparam int SD = 45;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic clear_overrun = 1'b0;
  logic [NV*PW-1:0] per [2];
  logic [NV-1:0] en [2];
  logic [23:0] amp_a;
  logic [22:0] amp_b;
  logic overrun_a, overrun_b;

  always #5 clock = ~clock;

  square_voice_mixer_if #(.OUT_W(32)) ifa ();
  square_voice_mixer_if #(.OUT_W(24)) ifb ();

  square_voice_mixer #(.NUM_VOICES(NV), .PERIOD_W(PW), .AMP_W(24), .OUT_W(32), .SAMPLE_DIV(SD)) dut_a (
    .clock(clock), .reset_n(reset_n), .period(per[0]), .voice_en(en[0]), .amplitude(amp_a),
    .clear_overrun(clear_overrun), .sample(ifa.master), .overrun(overrun_a));

  square_voice_mixer #(.NUM_VOICES(NV), .PERIOD_W(PW), .AMP_W(23), .OUT_W(24), .SAMPLE_DIV(SD)) dut_b (
    .clock(clock), .reset_n(reset_n), .period(per[1]), .voice_en(en[1]), .amplitude(amp_b),
    .clear_overrun(clear_overrun), .sample(ifb.master), .overrun(overrun_b));

  int checks = 0;
  int fails = 0;

  task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // model: each voice is a position within its current period; samples follow tick timing
  int     cyc;
  int     snap_at;
  int     pos [2][NV];
  int     len [2][NV];
  int     load_at [2];
  longint pend [2];
  longint exp_out [2];
  bit     exp_valid [2];
  bit     exp_ovr [2];

  function automatic longint amp_of(input int d);
    return (d == 0) ? longint'(amp_a) : longint'(amp_b);
  endfunction

  function automatic bit rdy(input int d);
    return (d == 0) ? ifa.sample_ready : ifb.sample_ready;
  endfunction

  function automatic longint clamp(input longint x, input int w);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic bit model_phase(input int d, input int v);
    return pos[d][v] < (len[d][v] + 1) / 2;
  endfunction

  task automatic model_reset();
    cyc = 0;
    snap_at = -1;
    for (int d = 0; d < 2; d++) begin
      load_at[d] = -1; pend[d] = 0; exp_out[d] = 0; exp_valid[d] = 0; exp_ovr[d] = 0;
      for (int v = 0; v < NV; v++) begin pos[d][v] = 0; len[d][v] = 1; end
    end
  endtask

  task automatic model_step();
    longint sum;
    bit set;
    for (int d = 0; d < 2; d++) begin
      if (cyc == snap_at) begin
        sum = 0;
        for (int v = 0; v < NV; v++)
          if (en[d][v] && len[d][v] > 1) sum += model_phase(d, v) ? amp_of(d) : -amp_of(d);
        pend[d] = clamp(sum, (d == 0) ? 32 : 24);
        load_at[d] = cyc + NV + 1;
      end
      set = (cyc == load_at[d]) && exp_valid[d] && !rdy(d);
      if (set) exp_ovr[d] = 1;
      else if (clear_overrun) exp_ovr[d] = 0;
      if (cyc == load_at[d]) begin exp_out[d] = pend[d]; exp_valid[d] = 1; end
      else if (exp_valid[d] && rdy(d)) exp_valid[d] = 0;
      for (int v = 0; v < NV; v++) begin
        if (pos[d][v] == len[d][v] - 1) begin
          pos[d][v] = 0;
          len[d][v] = int'(per[d][v*PW +: PW]) + 1;
        end else begin
          pos[d][v]++;
        end
      end
    end
    if (cyc % SD == SD - 1) snap_at = cyc + 1;
    cyc++;
  endtask

  initial model_reset();

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  always @(negedge clock) begin
    check("valid_a", ifa.sample_valid, exp_valid[0]);
    check("out_a", $signed(ifa.sample_out), exp_out[0]);
    check("overrun_a", overrun_a, exp_ovr[0]);
    check("valid_b", ifb.sample_valid, exp_valid[1]);
    check("out_b", $signed(ifb.sample_out), exp_out[1]);
    check("overrun_b", overrun_b, exp_ovr[1]);
    if (len[0][0] > 1) check("phase_a0", dut_a.g_voice[0].u_voice.phase, model_phase(0, 0));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic set_period_a0(input int p);
    per[0][0 +: PW] = PW'(p);
  endtask

  initial begin
    per[0] = {19'd6, 19'd0, 19'd13, 19'd9};
    per[1] = {19'd79, 19'd79, 19'd79, 19'd79};
    en[0] = 4'b0001;
    en[1] = 4'b1111;
    amp_a = 24'd10000000;
    amp_b = 23'd8388607;
    ifa.sample_ready = 1'b0;
    ifb.sample_ready = 1'b0;

    // reset values
    step(3);
    check("rst_valid_a", ifa.sample_valid, 0);
    check("rst_out_a", $signed(ifa.sample_out), 0);
    check("rst_ovr_a", overrun_a, 0);
    check("rst_valid_b", ifb.sample_valid, 0);
    reset_n = 1'b1;
    ifa.sample_ready = 1'b1;
    ifb.sample_ready = 1'b1;

    // first sample lands SAMPLE_DIV+NUM_VOICES+2 cycles after release
    step(50);
    check("lat_not_yet", ifa.sample_valid, 0);
    step(1);
    check("lat_valid_a", ifa.sample_valid, 1);
    check("s1_a", $signed(ifa.sample_out), 10000000);
    check("s1_b_clamp_lo", $signed(ifb.sample_out), -8388608);
    step(45);
    check("s2_a", $signed(ifa.sample_out), -10000000);
    check("s2_b_clamp_hi", $signed(ifb.sample_out), 8388607);
    step(45);
    check("s3_a", $signed(ifa.sample_out), 10000000);

    // overrun on A; on B the new sample lands in the same cycle as acceptance
    ifa.sample_ready = 1'b0;
    ifb.sample_ready = 1'b0;
    step(44);
    ifb.sample_ready = 1'b1;
    step(1);
    check("ovr_set_a", overrun_a, 1);
    check("ovr_valid_a", ifa.sample_valid, 1);
    check("ovr_out_a", $signed(ifa.sample_out), -10000000);
    check("coincide_ovr_b", overrun_b, 0);
    check("coincide_valid_b", ifb.sample_valid, 1);
    clear_overrun = 1'b1;
    step(1);
    clear_overrun = 1'b0;
    check("ovr_clear_a", overrun_a, 0);
    check("ovr_hold_valid_a", ifa.sample_valid, 1);
    ifa.sample_ready = 1'b1;

    // cycle 187: voice0 is mid-period; the new period waits for the reload at 191
    set_period_a0(19);
    step(3);
    check("old_half_190", dut_a.g_voice[0].u_voice.phase, 0);
    step(1);
    check("new_start_191", dut_a.g_voice[0].u_voice.phase, 1);
    step(9);
    check("new_high_200", dut_a.g_voice[0].u_voice.phase, 1);
    step(1);
    check("new_low_201", dut_a.g_voice[0].u_voice.phase, 0);
    set_period_a0(0);
    step(30);
    check("silent_valid_a", ifa.sample_valid, 1);
    check("silent_out_a", $signed(ifa.sample_out), 0);

    // reset while the mixer is on the third accumulate step
    set_period_a0(9);
    step(42);
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid_a", ifa.sample_valid, 0);
    check("rst_mid_valid_b", ifb.sample_valid, 0);
    step(1);
    reset_n = 1'b1;
    step(50);
    check("post_rst_quiet", ifa.sample_valid, 0);
    step(1);
    check("post_rst_valid", ifa.sample_valid, 1);
    check("post_rst_out_a", $signed(ifa.sample_out), 10000000);
    check("post_rst_out_b", $signed(ifb.sample_out), -8388608);
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
